// File: rtl/mem_split_arbiter_if.sv
// Host and target bus bundle for the two-host shared-memory arbiter.
// The slave modport is the arbiter's view; master is the hosts/memory side.
interface mem_split_arbiter_if;
  logic        host0_req;
  logic        host1_req;
  logic        host0_ack;
  logic        host1_ack;
  logic        host0_we;
  logic        host1_we;
  logic [31:0] host0_addr;
  logic [31:0] host1_addr;
  logic [31:0] host0_wdata;
  logic [31:0] host1_wdata;
  logic [3:0]  host0_be;
  logic [3:0]  host1_be;
  logic        host0_resp;
  logic        host1_resp;
  logic [31:0] host0_rdata;
  logic [31:0] host1_rdata;
  logic        target_req;
  logic        target_ack;
  logic        target_we;
  logic [31:0] target_addr;
  logic [31:0] target_wdata;
  logic [3:0]  target_be;
  logic        target_resp;
  logic [31:0] target_rdata;

  modport slave (
    input  host0_req, host1_req, host0_we, host1_we, host0_addr, host1_addr,
           host0_wdata, host1_wdata, host0_be, host1_be,
           target_ack, target_resp, target_rdata,
    output host0_ack, host1_ack, host0_resp, host1_resp, host0_rdata, host1_rdata,
           target_req, target_we, target_addr, target_wdata, target_be
  );

  modport master (
    output host0_req, host1_req, host0_we, host1_we, host0_addr, host1_addr,
           host0_wdata, host1_wdata, host0_be, host1_be,
           target_ack, target_resp, target_rdata,
    input  host0_ack, host1_ack, host0_resp, host1_resp, host0_rdata, host1_rdata,
           target_req, target_we, target_addr, target_wdata, target_be
  );
endinterface

// File: rtl/mem_split_arbiter.sv
// Two-host round-robin arbiter onto one split-transaction memory port; a tag
// FIFO remembers which host issued each read so in-order responses are routed back.
module mem_split_arbiter #(
  parameter int RESP_FIFO_POW = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  mem_split_arbiter_if.slave       bus,
  output logic [RESP_FIFO_POW:0]   outstanding_o,
  output logic                     err_o
);

  localparam int D = 1 << RESP_FIFO_POW;
  localparam logic [RESP_FIFO_POW:0] DEPTH = (RESP_FIFO_POW + 1)'(D);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic                     rr;
  logic                     grant;
  logic [1:0]               perm;
  logic [D-1:0]             tags;
  logic [RESP_FIFO_POW-1:0] wr_ptr;
  logic [RESP_FIFO_POW-1:0] rd_ptr;
  logic [RESP_FIFO_POW:0]   count;
  logic                     accept;
  logic                     push;
  logic                     pop;
  logic                     head;

  // Reads are held back while every tag slot is in use; writes never need a slot.
  assign perm[0] = bus.host0_req & (bus.host0_we | (count < DEPTH));
  assign perm[1] = bus.host1_req & (bus.host1_we | (count < DEPTH));

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    grant = rr;
    case (state)
      LOCK0:   grant = 1'b0;
      LOCK1:   grant = 1'b1;
      default: begin
        if (perm[0] && perm[1]) grant = ~rr;
        else if (perm[0])       grant = 1'b0;
        else if (perm[1])       grant = 1'b1;
      end
    endcase
  end

  assign bus.target_req   = rst_i & perm[grant];
  assign bus.target_we    = grant ? bus.host1_we    : bus.host0_we;
  assign bus.target_addr  = grant ? bus.host1_addr  : bus.host0_addr;
  assign bus.target_wdata = grant ? bus.host1_wdata : bus.host0_wdata;
  assign bus.target_be    = grant ? bus.host1_be    : bus.host0_be;

  assign accept = bus.target_req & bus.target_ack;
  assign push   = accept & ~bus.target_we;
  assign pop    = rst_i & bus.target_resp & (count != '0);
  assign head   = tags[rd_ptr];

  assign bus.host0_ack   = accept & ~grant;
  assign bus.host1_ack   = accept & grant;
  assign bus.host0_resp  = pop & ~head;
  assign bus.host1_resp  = pop & head;
  assign bus.host0_rdata = bus.target_rdata;
  assign bus.host1_rdata = bus.target_rdata;
  assign outstanding_o   = count;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (bus.target_req && !bus.target_ack) state_nxt = grant ? LOCK1 : LOCK0;
      LOCK0, LOCK1: if (accept) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      rr     <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_o  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) rr <= grant;
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.target_resp && (count == '0)) err_o <= 1'b1;
    end
  end

  // NOTE: tag storage is not reset; only slots between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk_i) begin
    if (push) tags[wr_ptr] <= grant;
  end

endmodule

// File: doc/mem_split_arbiter.md
MEM_SPLIT_ARBITER -- requirements
Module: mem_split_arbiter

Interface
REQ-001 The block SHALL take one parameter: RESP_FIFO_POW, default 4, log2 of the maximum number of outstanding read transactions (tag FIFO depth D = 2^RESP_FIFO_POW).
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 The block SHALL provide these ports (name  direction  width  meaning):
  clk_i  in  1  clock, all state updates on rising edge
  rst_i  in  1  synchronous active-low reset
  host0_req / host1_req  in  1  request valid (host0 = instr bus, host1 = data bus)
  host0_ack / host1_ack  out  1  request accepted
  host0_we / host1_we  in  1  1 = write, 0 = read
  host0_addr / host1_addr  in  32  byte address
  host0_wdata / host1_wdata  in  32  write data
  host0_be / host1_be  in  4  byte enables
  host0_resp / host1_resp  out  1  read response valid
  host0_rdata / host1_rdata  out  32  read data
  target_req  out  1  request to shared memory
  target_ack  in  1  memory accepted request
  target_we / target_addr / target_wdata / target_be  out  1/32/32/4  muxed request fields
  target_resp  in  1  read response valid (in read-accept order)
  target_rdata  in  32  read data
  outstanding_o  out  RESP_FIFO_POW+1  reads accepted by target, response pending
  err_o  out  1  sticky protocol error

Function
REQ-004 Request handshake SHALL complete in a cycle where req and ack are both 1; a host holds req and all fields stable until ack.
REQ-005 Arbiter FSM SHALL have states IDLE, LOCK0, LOCK1; the granted host's fields SHALL be driven onto target_* combinationally, target_req = granted host's req & permitted.
REQ-006 In IDLE, when exactly one permitted host requests it SHALL be granted; when both request, the host other than the last accepted one (rr pointer) SHALL be granted.
REQ-007 In IDLE, grant with target_ack=1 in the same cycle SHALL stay IDLE; grant with target_ack=0 SHALL move to LOCKn (n = granted host).
REQ-008 In LOCKn, host n SHALL remain granted regardless of the other host's req until target_ack=1, then return to IDLE.
REQ-009 On each accepted request the rr pointer SHALL be set to the accepted host id.
REQ-010 A read (we=0) SHALL be permitted only when outstanding_o < D; writes are always permitted; a non-permitted host is neither granted nor acked.
REQ-011 hostN_ack SHALL equal target_ack & target_req & (grant == N); the non-granted host's ack SHALL be 0.
REQ-012 On accepted read, the granted host id SHALL be pushed into the tag FIFO; writes push nothing and expect no response.
REQ-013 On target_resp=1 with outstanding_o > 0, the block SHALL pulse resp of the host at FIFO head in the same cycle (combinational, zero latency) and pop the head.
REQ-014 host0_rdata and host1_rdata SHALL both be driven with target_rdata at all times.
REQ-015 target_resp=1 with outstanding_o = 0 (including same-cycle accept of the first read) SHALL be dropped (no host resp) and SHALL set err_o.
REQ-016 Simultaneous push and pop SHALL both take effect, outstanding_o unchanged; FIFO pointers SHALL wrap modulo D.
REQ-017 outstanding_o SHALL range 0..D and never over/underflow.

Reset
REQ-018 While rst_i=0: FSM to IDLE, rr pointer = host1 (host0 wins first contention), FIFO emptied, outstanding_o=0, err_o=0; target_req, host acks and host resps forced to 0.
REQ-019 Reset mid-transaction SHALL discard lock and all pending tags; responses arriving afterward with outstanding_o=0 SHALL set err_o per REQ-015.

Verification
REQ-020 Both hosts read at reset release, target_ack=1 always -> host0 acked cycle 1, host1 cycle 2, alternating while both request.
REQ-021 host0 read, target_ack held 0 for 3 cycles, host1 requests meanwhile -> target_addr stays host0 addr, host1_ack=0 until host0 accepted.
REQ-022 Reads accepted host1, host0, host1; three target_resp with rdata 0xA, 0xB, 0xC -> host1_resp with 0xA, host0_resp with 0xB, host1_resp with 0xC; outstanding_o 3->0.
REQ-023 RESP_FIFO_POW=2, 4 reads accepted without resp -> outstanding_o=4, 5th read not presented (target_req=0) while a write from other host is accepted; one resp -> 5th read proceeds.
REQ-024 target_resp with outstanding_o=0 -> no host resp, err_o=1 and stays 1 until rst_i=0.
REQ-025 rst_i=0 for one cycle with 2 reads outstanding and LOCK1 active -> outstanding_o=0, FSM IDLE, target_req=0 next cycle.
